// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the 32-bit pattern generator/checker pair.
// The generator and the checker both call lfsr_next, so their polynomials stay identical.
package lfsr_pkg;

  localparam int LFSR_W = 32;

  // Taps for x^32 + x^22 + x^2 + x + 1 (Fibonacci form, shifting left)
  localparam int TAP_A = 31;
  localparam int TAP_B = 21;
  localparam int TAP_C = 1;
  localparam int TAP_D = 0;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Self-synchronising LFSR word checker: lock/unlock FSM, flywheel predictor, saturating error count.
// All outputs are registered one cycle after the valid beat. There is no backpressure: the source qualifies beats with valid_i only.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 4,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 valid_i,
  input  logic [LFSR_W-1:0]    data_i,
  input  logic                 clear_i,
  output logic                 locked_o,
  output logic                 error_o,
  output logic [ERR_CNT_W-1:0] err_count_o,
  output logic [LFSR_W-1:0]    expected_o
);

  localparam int MR_W = $clog2(LOCK_COUNT + 1);
  localparam int XR_W = $clog2(UNLOCK_COUNT + 1);

  lfsr_state_t          r_state;
  logic                 r_locked;
  logic                 r_error;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic [LFSR_W-1:0]    r_expected;
  logic [MR_W-1:0]      r_match_run;
  logic [XR_W-1:0]      r_miss_run;

  logic              w_hit;
  logic              w_data_nz;
  logic [LFSR_W-1:0] w_next_data;
  logic [LFSR_W-1:0] w_next_exp;
  logic [MR_W-1:0]   w_match_inc;
  logic [XR_W-1:0]   w_miss_inc;
  logic              w_err_inc;
  logic              w_cnt_sat;

  assign w_hit       = (data_i == r_expected);
  assign w_data_nz   = |data_i;
  assign w_next_data = lfsr_next(data_i);
  assign w_next_exp  = lfsr_next(r_expected);
  assign w_match_inc = r_match_run + MR_W'(1);
  assign w_miss_inc  = r_miss_run + XR_W'(1);
  assign w_err_inc   = valid_i && (r_state == LOCKED) && !w_hit;
  assign w_cnt_sat   = &r_err_count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= HUNT;
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_err_count <= '0;
      r_expected  <= '0;
      r_match_run <= '0;
      r_miss_run  <= '0;
    end else begin
      r_error <= w_err_inc;

      // Clear has priority over a coincident increment
      if (clear_i) begin
        r_err_count <= '0;
      end else if (w_err_inc && !w_cnt_sat) begin
        r_err_count <= r_err_count + ERR_CNT_W'(1);
      end

      if (valid_i) begin
        case (r_state)
          HUNT: begin
            if (w_data_nz) begin
              r_expected  <= w_next_data;
              r_match_run <= '0;
              r_state     <= VERIFY;
            end
          end

          VERIFY: begin
            if (w_hit) begin
              r_expected <= w_next_data;
              if (w_match_inc == MR_W'(LOCK_COUNT)) begin
                r_state     <= LOCKED;
                r_locked    <= 1'b1;
                r_match_run <= '0;
                r_miss_run  <= '0;
              end else begin
                r_match_run <= w_match_inc;
              end
            end else if (w_data_nz) begin
              r_expected  <= w_next_data;
              r_match_run <= '0;
            end else begin
              r_match_run <= '0;
              r_state     <= HUNT;
            end
          end

          LOCKED: begin
            // Flywheel: received data never reloads the predictor once locked
            r_expected <= w_next_exp;
            if (w_hit) begin
              r_miss_run <= '0;
            end else if (w_miss_inc == XR_W'(UNLOCK_COUNT)) begin
              r_miss_run <= '0;
              r_locked   <= 1'b0;
              r_state    <= HUNT;
            end else begin
              r_miss_run <= w_miss_inc;
            end
          end

          default: begin
            r_locked <= 1'b0;
            r_state  <= HUNT;
          end
        endcase
      end
    end
  end

  assign locked_o    = r_locked;
  assign error_o     = r_error;
  assign err_count_o = r_err_count;
  assign expected_o  = r_expected;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock/unlock, flywheel errors, valid gaps, counter saturation and clear.
module tb_lfsr_checker;

  logic        clk_i;
  logic        reset_i;
  logic        valid_i;
  logic [31:0] data_i;
  logic        clear_i;

  logic        locked_o,  locked4_o;
  logic        error_o,   error4_o;
  logic [15:0] err_count_o;
  logic [3:0]  err_count4_o;
  logic [31:0] expected_o, expected4_o;

  int n_assert = 0;
  int n_fail   = 0;

  lfsr_checker u_dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .clear_i     (clear_i),
    .locked_o    (locked_o),
    .error_o     (error_o),
    .err_count_o (err_count_o),
    .expected_o  (expected_o)
  );

  lfsr_checker #(.ERR_CNT_W(4)) u_dut4 (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .clear_i     (clear_i),
    .locked_o    (locked4_o),
    .error_o     (error4_o),
    .err_count_o (err_count4_o),
    .expected_o  (expected4_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] nxt(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: inputs applied at the falling edge, outputs sampled 1 time unit after the rising edge
  task automatic beat(input logic v, input logic [31:0] d, input logic clr);
    @(negedge clk_i);
    valid_i = v;
    data_i  = d;
    clear_i = clr;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    clear_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  logic [31:0] m;
  logic [31:0] seq [5];
  int          k;
  int          guard;

  initial begin
    reset_i = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    clear_i = 1'b0;
    seq[0] = 32'h1; seq[1] = 32'h3; seq[2] = 32'h6; seq[3] = 32'hD; seq[4] = 32'h1B;

    // Reset state
    do_reset();
    chk("rst_locked", {31'b0, locked_o}, 32'd0);
    chk("rst_error",  {31'b0, error_o},  32'd0);
    chk("rst_cnt",    {16'b0, err_count_o}, 32'd0);
    chk("rst_exp",    expected_o, 32'd0);

    // HUNT ignores all-zero words
    for (int i = 0; i < 10; i++) beat(1'b1, 32'h0, 1'b0);
    chk("hunt0_locked", {31'b0, locked_o}, 32'd0);
    chk("hunt0_exp",    expected_o, 32'd0);

    // Seed, one match, then a zero word drops back to HUNT
    beat(1'b1, 32'h1, 1'b0);
    chk("seed_exp", expected_o, 32'h3);
    beat(1'b1, 32'h3, 1'b0);
    chk("verify_exp", expected_o, 32'h6);
    beat(1'b1, 32'h0, 1'b0);
    chk("zero_abort_locked", {31'b0, locked_o}, 32'd0);
    // From HUNT: 0x6 is a fresh seed, so four more matches are needed
    beat(1'b1, 32'h6, 1'b0);
    beat(1'b1, 32'hD, 1'b0);
    beat(1'b1, 32'h1B, 1'b0);
    beat(1'b1, 32'h36, 1'b0);
    chk("rehunt_not_locked", {31'b0, locked_o}, 32'd0);
    beat(1'b1, 32'h6D, 1'b0);
    chk("rehunt_locked", {31'b0, locked_o}, 32'd1);

    // Basic lock from reset
    do_reset();
    beat(1'b1, 32'h1, 1'b0);
    beat(1'b1, 32'h3, 1'b0);
    beat(1'b1, 32'h6, 1'b0);
    beat(1'b1, 32'hD, 1'b0);
    chk("lock_early", {31'b0, locked_o}, 32'd0);
    beat(1'b1, 32'h1B, 1'b0);
    chk("lock_locked", {31'b0, locked_o}, 32'd1);
    chk("lock_cnt",    {16'b0, err_count_o}, 32'd0);
    chk("lock_exp",    expected_o, 32'h36);
    chk("lock_err",    {31'b0, error_o}, 32'd0);

    // Idle cycle changes nothing
    beat(1'b0, 32'hDEAD_BEEF, 1'b0);
    chk("idle_exp", expected_o, 32'h36);
    chk("idle_err", {31'b0, error_o}, 32'd0);

    // Single corrupted beat in LOCKED, then predictor keeps flywheeling
    beat(1'b1, 32'h16, 1'b0);
    chk("err1_pulse",  {31'b0, error_o}, 32'd1);
    chk("err1_cnt",    {16'b0, err_count_o}, 32'd1);
    chk("err1_locked", {31'b0, locked_o}, 32'd1);
    chk("err1_exp",    expected_o, 32'h6D);
    beat(1'b1, 32'h6D, 1'b0);
    chk("err1_after_pulse", {31'b0, error_o}, 32'd0);
    chk("err1_after_exp",   expected_o, 32'hDB);
    beat(1'b1, 32'hDB, 1'b0);
    chk("err1_after2_cnt", {16'b0, err_count_o}, 32'd1);
    chk("err1_after2_exp", expected_o, 32'h1B6);
    m = 32'h1B6;

    // Clear on an idle cycle, then four consecutive misses drop lock
    beat(1'b0, 32'h0, 1'b1);
    chk("clear_idle_cnt", {16'b0, err_count_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, m ^ 32'h100, 1'b0);
      m = nxt(m);
      chk("unlock_pulse", {31'b0, error_o}, 32'd1);
      chk("unlock_locked", {31'b0, locked_o}, (i == 3) ? 32'd0 : 32'd1);
    end
    chk("unlock_cnt", {16'b0, err_count_o}, 32'd4);

    // Relock: seed, a silent VERIFY re-seed, then four good beats
    beat(1'b1, 32'hACE1_2345, 1'b0);
    beat(1'b1, 32'h1234_5678, 1'b0);
    chk("verify_silent_err", {31'b0, error_o}, 32'd0);
    chk("verify_silent_cnt", {16'b0, err_count_o}, 32'd4);
    m = nxt(32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, m, 1'b0);
      m = nxt(m);
      chk("relock_locked", {31'b0, locked_o}, (i == 3) ? 32'd1 : 32'd0);
    end
    chk("relock_exp", expected_o, m);

    // Random valid gaps during the lock sequence
    do_reset();
    k = 0;
    guard = 0;
    while (k < 5 && guard < 200) begin
      guard++;
      if ($urandom_range(0, 1) == 1) begin
        beat(1'b1, seq[k], 1'b0);
        k++;
        chk("gap_locked", {31'b0, locked_o}, (k == 5) ? 32'd1 : 32'd0);
      end else begin
        beat(1'b0, $urandom, 1'b0);
      end
      chk("gap_err", {31'b0, error_o}, 32'd0);
    end
    chk("gap_beats", k, 32'd5);
    chk("gap_exp", expected_o, 32'h36);
    m = 32'h36;

    // Saturation of the narrow counter, errors interleaved with matches to stay locked
    beat(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      beat(1'b1, m ^ 32'h1, 1'b0);
      m = nxt(m);
      beat(1'b1, m, 1'b0);
      m = nxt(m);
    end
    chk("sat_cnt4",   {28'b0, err_count4_o}, 32'd15);
    chk("sat_cnt16",  {16'b0, err_count_o}, 32'd20);
    chk("sat_locked", {31'b0, locked4_o}, 32'd1);
    beat(1'b1, m ^ 32'h1, 1'b1);
    m = nxt(m);
    chk("clr_err_pulse", {31'b0, error4_o}, 32'd1);
    chk("clr_err_cnt4",  {28'b0, err_count4_o}, 32'd0);
    chk("clr_err_cnt16", {16'b0, err_count_o}, 32'd0);

    // Reset overrides a coincident valid beat
    @(negedge clk_i);
    reset_i = 1'b1;
    valid_i = 1'b1;
    data_i  = m ^ 32'h1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    valid_i = 1'b0;
    chk("midrst_locked", {31'b0, locked_o}, 32'd0);
    chk("midrst_err",    {31'b0, error_o}, 32'd0);
    chk("midrst_exp",    expected_o, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
